// File: rtl/lcd_nibble_ctrl.sv
// 4-bit HD44780-style LCD write controller: runs the power-up nibble sequence and
// configuration bytes, then sends requested bytes as upper/lower nibble strobes.
module lcd_nibble_ctrl #(
  parameter int T_PWRUP = 750000,
  parameter int T_INIT1 = 205000,
  parameter int T_INIT2 = 5000,
  parameter int T_INIT3 = 2000,
  parameter int T_SU    = 2,
  parameter int T_E_HI  = 12,
  parameter int T_NIB   = 50,
  parameter int T_CMD   = 2000,
  parameter int T_CLR   = 82000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rs,
  input  logic [7:0] req_data,
  output logic       init_done,
  output logic       busy,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [3:0] sf_d
);

  function automatic int max2(int a, int b);
    return (a > b) ? a : b;
  endfunction

  localparam int T_MAX = max2(max2(max2(T_PWRUP, T_INIT1), max2(T_INIT2, T_INIT3)),
                              max2(max2(T_SU, T_E_HI), max2(max2(T_NIB, T_CMD), T_CLR)));
  localparam int CW = $clog2(T_MAX + 1);

  typedef enum logic [3:0] {
    PWRUP, INIT_NIB, INIT_WAIT, CFG, IDLE, SETUP, E_HI, E_GAP, WAIT
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    step, step_n;
  logic          lower, lower_n;
  logic          byte_rs, byte_rs_n;
  logic [7:0]    byte_data, byte_data_n;
  logic [3:0]    nib_q, nib_n;
  logic          rs_q, rs_n;
  logic          done_q, done_n;
  logic          cnt_last;
  logic          long_wait;

  // step: 0..3 init nibbles, 4..7 configuration bytes, 8 once initialised
  function automatic logic [7:0] cfg_byte(logic [3:0] s);
    case (s)
      4'd4:    return 8'h28;
      4'd5:    return 8'h06;
      4'd6:    return 8'h0C;
      default: return 8'h01;
    endcase
  endfunction

  function automatic logic [CW-1:0] init_wait_len(logic [3:0] s);
    case (s)
      4'd0:    return CW'(T_INIT1);
      4'd1:    return CW'(T_INIT2);
      default: return CW'(T_INIT3);
    endcase
  endfunction

  assign cnt_last  = (cnt <= CW'(1));
  assign long_wait = !byte_rs && (byte_data == 8'h01 || byte_data == 8'h02);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= PWRUP;
      cnt       <= CW'(T_PWRUP);
      step      <= 4'd0;
      lower     <= 1'b0;
      byte_rs   <= 1'b0;
      byte_data <= 8'h00;
      nib_q     <= 4'h0;
      rs_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      step      <= step_n;
      lower     <= lower_n;
      byte_rs   <= byte_rs_n;
      byte_data <= byte_data_n;
      nib_q     <= nib_n;
      rs_q      <= rs_n;
      done_q    <= done_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt_last ? cnt : cnt - CW'(1);
    step_n      = step;
    lower_n     = lower;
    byte_rs_n   = byte_rs;
    byte_data_n = byte_data;
    nib_n       = nib_q;
    rs_n        = rs_q;
    done_n      = done_q;

    case (state)
      PWRUP: if (cnt_last) begin
        state_n = INIT_NIB;
        cnt_n   = CW'(T_SU);
      end
      INIT_NIB: if (cnt_last) begin
        state_n = E_HI;
        cnt_n   = CW'(T_E_HI);
      end
      E_HI: if (cnt_last) begin
        if (step < 4'd4) begin
          state_n = INIT_WAIT;
          cnt_n   = init_wait_len(step);
        end else if (!lower) begin
          state_n = E_GAP;
          cnt_n   = CW'(T_NIB);
          lower_n = 1'b1;
        end else begin
          state_n = WAIT;
          cnt_n   = long_wait ? CW'(T_CLR) : CW'(T_CMD);
        end
      end
      E_GAP, SETUP: if (cnt_last) begin
        state_n = (state == E_GAP) ? SETUP : E_HI;
        cnt_n   = (state == E_GAP) ? CW'(T_SU) : CW'(T_E_HI);
      end
      INIT_WAIT: if (cnt_last) begin
        step_n = step + 4'd1;
        if (step == 4'd3) begin
          state_n = CFG;
        end else begin
          state_n = INIT_NIB;
          cnt_n   = CW'(T_SU);
        end
      end
      CFG: begin
        byte_data_n = cfg_byte(step);
        byte_rs_n   = 1'b0;
        lower_n     = 1'b0;
        state_n     = SETUP;
        cnt_n       = CW'(T_SU);
      end
      WAIT: if (cnt_last) begin
        if (step < 4'd7) begin
          step_n  = step + 4'd1;
          state_n = CFG;
        end else begin
          step_n  = 4'd8;
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      IDLE: if (req_valid && done_q) begin
        byte_data_n = req_data;
        byte_rs_n   = req_rs;
        lower_n     = 1'b0;
        state_n     = SETUP;
        cnt_n       = CW'(T_SU);
      end
      default: state_n = PWRUP;
    endcase

    // Bus lines only move when a setup phase begins, so they are stable under lcd_e
    if (state_n == SETUP && state != SETUP) begin
      nib_n = lower_n ? byte_data_n[3:0] : byte_data_n[7:4];
      rs_n  = byte_rs_n;
    end
    if (state_n == INIT_NIB && state != INIT_NIB) begin
      nib_n = (step_n == 4'd3) ? 4'h2 : 4'h3;
      rs_n  = 1'b0;
    end
  end

  assign lcd_e     = (state == E_HI);
  assign lcd_rs    = rs_q;
  assign sf_d      = nib_q;
  assign lcd_rw    = 1'b0;
  assign busy      = (state != IDLE);
  assign req_ready = (state == IDLE) && done_q;
  assign init_done = done_q;

endmodule
